// File: rtl/seq_add_pkg.sv
// ============================================================================
// Module   : seq_add_pkg
// Brief    : Shared slice width and controller states for seq_add_wide.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_add_pkg;

  localparam int SLICE_W = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ADD  = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/seq_add_wide_csa.sv
// ============================================================================
// Module   : CSA_16bit
// Brief    : 16-bit carry select adder, two 8-bit halves.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module CSA_16bit
  import seq_add_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  localparam int c_HALF = SLICE_W / 2;

  logic [c_HALF:0] w_lo;
  logic [c_HALF:0] w_hi0;
  logic [c_HALF:0] w_hi1;

  assign w_lo  = {1'b0, a[c_HALF-1:0]} + {1'b0, b[c_HALF-1:0]} + {{c_HALF{1'b0}}, cin};
  // Upper half is precomputed for both possible carries and picked by the low carry.
  assign w_hi0 = {1'b0, a[SLICE_W-1:c_HALF]} + {1'b0, b[SLICE_W-1:c_HALF]};
  assign w_hi1 = {1'b0, a[SLICE_W-1:c_HALF]} + {1'b0, b[SLICE_W-1:c_HALF]} + {{c_HALF{1'b0}}, 1'b1};

  assign sum  = {(w_lo[c_HALF] ? w_hi1[c_HALF-1:0] : w_hi0[c_HALF-1:0]), w_lo[c_HALF-1:0]};
  assign cout = w_lo[c_HALF] ? w_hi1[c_HALF] : w_hi0[c_HALF];

endmodule

`default_nettype wire

// File: rtl/seq_add_wide.sv
// ============================================================================
// Module   : seq_add_wide
// Brief    : Multi-cycle wide adder, one 16-bit slice per clock, LSB first.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_add_wide
  import seq_add_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int N     = WIDTH / SLICE_W;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] c_LAST = IDX_W'(N - 1);

  state_t                      r_state;
  state_t                      w_state_next;
  logic [N-1:0][SLICE_W-1:0]   r_a;
  logic [N-1:0][SLICE_W-1:0]   r_b;
  logic [N-1:0][SLICE_W-1:0]   r_sum;
  logic [IDX_W-1:0]            r_idx;
  logic                        r_carry;
  logic                        r_cout;
  logic                        r_done;
  logic [SLICE_W-1:0]          w_slice_sum;
  logic                        w_slice_cout;

  CSA_16bit u_csa (
    .a    (r_a[r_idx]),
    .b    (r_b[r_idx]),
    .cin  (r_carry),
    .sum  (w_slice_sum),
    .cout (w_slice_cout)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = ADD;
      ADD:     if (r_idx == c_LAST) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= 1'b0;
      if (r_state == IDLE) begin
        // Previous sum stays visible until overwritten slice by slice.
        if (start) begin
          r_a     <= a;
          r_b     <= b;
          r_carry <= cin;
          r_idx   <= '0;
        end
      end else begin
        r_sum[r_idx] <= w_slice_sum;
        r_carry      <= w_slice_cout;
        r_idx        <= r_idx + 1'b1;
        if (r_idx == c_LAST) begin
          r_cout <= w_slice_cout;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign busy = (r_state == ADD);
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

`default_nettype wire

// File: tb/tb_seq_add_wide.sv
// ============================================================================
// Module   : tb_seq_add_wide
// Brief    : Scoreboard bench for seq_add_wide against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_add_wide;

  localparam int WIDTH = 64;
  localparam int N     = WIDTH / 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  seq_add_wide #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  int           checks = 0;
  int           errors = 0;
  int           cyc    = 0;
  logic [WIDTH:0] exp_q[$];
  int           due_q[$];
  bit           acc_valid = 1'b0;
  int           last_acc  = 0;
  bit           b2b       = 1'b0;
  int           b2b_seen  = 0;
  int           last_done = 0;

  task automatic check(input string name, input logic [WIDTH:0] act, input logic [WIDTH:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: samples just after each rising edge, pops the scoreboard on done.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!rst) begin
        check("busy", {{WIDTH{1'b0}}, busy},
              {{WIDTH{1'b0}}, (acc_valid && cyc >= last_acc && cyc < last_acc + N)});
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          check("spurious_done", {{WIDTH{1'b0}}, done}, '0);
        end else begin
          check("result", {cout, sum}, exp_q.pop_front());
          check("latency", (WIDTH+1)'(cyc), (WIDTH+1)'(due_q.pop_front()));
          if (b2b) begin
            if (b2b_seen > 0) check("b2b_gap", (WIDTH+1)'(cyc - last_done), (WIDTH+1)'(N + 1));
            b2b_seen++;
          end
          last_done = cyc;
        end
      end
    end
  end

  // Drive operands with start high until the DUT is idle, then record the expectation.
  task automatic issue(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                       input logic ic, input bit hold);
    int t = 0;
    start = 1'b1;
    a = ia;
    b = ib;
    cin = ic;
    while (busy && t < 50) begin
      @(negedge clk);
      a = ia;
      b = ib;
      cin = ic;
      t++;
    end
    if (busy) begin
      check("accept_timeout", {{WIDTH{1'b0}}, busy}, '0);
      return;
    end
    exp_q.push_back({1'b0, ia} + {1'b0, ib} + {{WIDTH{1'b0}}, ic});
    due_q.push_back(cyc + 1 + N);
    last_acc  = cyc + 1;
    acc_valid = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      check("done_timeout", (WIDTH+1)'(exp_q.size()), '0);
      exp_q.delete();
      due_q.delete();
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_busy"}, {{WIDTH{1'b0}}, busy}, '0);
    check({tag, "_done"}, {{WIDTH{1'b0}}, done}, '0);
    check({tag, "_sum"},  {1'b0, sum}, '0);
    check({tag, "_cout"}, {{WIDTH{1'b0}}, cout}, '0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    repeat (2) @(negedge clk);
    check_cleared("reset");
    rst = 1'b0;
    @(negedge clk);

    issue('0, '0, 1'b0, 1'b0);
    drain();
    issue('1, '0, 1'b1, 1'b0);
    drain();
    issue('1, '1, 1'b0, 1'b0);
    drain();
    issue('1, '1, 1'b1, 1'b0);
    drain();

    // Re-pulse start with fresh operands on every ADD cycle.
    issue(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, 1'b0);
    for (int i = 0; i < N; i++) begin
      start = 1'b1;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      cin = 1'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    drain();

    // Abort mid-addition with a two-cycle reset.
    issue(64'hDEAD_BEEF_0000_FFFF, 64'h1234_5678_9ABC_DEF0, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    due_q.delete();
    acc_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_cleared("abort");
    rst = 1'b0;
    repeat (3 * N) @(negedge clk);

    b2b = 1'b1;
    for (int i = 0; i < 100; i++) begin
      issue({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'b1);
    end
    start = 1'b0;
    drain();
    b2b = 1'b0;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule

`default_nettype wire
